// File: rtl/program_sequencer_pkg.sv
// Shared types and encodings for the program sequencer: FSM states, opcode
// prefixes, register codes, reg_en bit positions and bus-source selects.
package program_sequencer_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Opcode prefixes, matched against the top bits of ir
  localparam logic [1:0] OP_MOV_PREFIX = 2'b10;
  localparam logic [2:0] OP_ALU_PREFIX = 3'b110;
  localparam logic [3:0] OP_JMP_PREFIX = 4'b1110;
  localparam logic [3:0] OP_JNZ_PREFIX = 4'b1111;

  // Register codes shared by load/mov fields (code 4 is o_reg as a
  // destination and r as a source)
  localparam logic [2:0] CODE_X0    = 3'd0;
  localparam logic [2:0] CODE_X1    = 3'd1;
  localparam logic [2:0] CODE_Y0    = 3'd2;
  localparam logic [2:0] CODE_Y1    = 3'd3;
  localparam logic [2:0] CODE_O_REG = 3'd4;
  localparam logic [2:0] CODE_R     = 3'd4;
  localparam logic [2:0] CODE_M     = 3'd5;
  localparam logic [2:0] CODE_I     = 3'd6;
  localparam logic [2:0] CODE_DM    = 3'd7;

  localparam int EN_X0    = 0;
  localparam int EN_X1    = 1;
  localparam int EN_Y0    = 2;
  localparam int EN_Y1    = 3;
  localparam int EN_R     = 4;
  localparam int EN_M     = 5;
  localparam int EN_I     = 6;
  localparam int EN_DM    = 7;
  localparam int EN_O_REG = 8;

  localparam logic [3:0] SRC_SEL_IMM   = 4'd8;
  localparam logic [3:0] SRC_SEL_IPINS = 4'd9;

  localparam logic [7:0] MOV_IPINS_OPCODE = 8'hA4;
  localparam logic [7:0] HALT_OPCODE      = 8'hBF;

  // Destination code to write enable; code 4 targets o_reg, not r
  function automatic logic [8:0] dst_onehot(input logic [2:0] dst);
    logic [8:0] en;
    en = '0;
    if (dst == CODE_O_REG) en[EN_O_REG] = 1'b1;
    else                   en[dst]      = 1'b1;
    return en;
  endfunction

endpackage

// File: rtl/program_sequencer_decoder.sv
// Combinational instruction decoder: ir and r_eq_0 to unit control signals.
// The halt opcode is recognised only when PROGRAM_SEQUENCER_HALT_EN is defined.
module seq_decoder
  import program_sequencer_pkg::*;
(
  input  logic [7:0] ir,
  input  logic       r_eq_0,
  output logic [8:0] reg_en,
  output logic [3:0] source_sel,
  output logic       i_sel,
  output logic       x_sel,
  output logic       y_sel,
  output logic       jump_taken,
  output logic       halt_op
);

  always_comb begin
    reg_en     = '0;
    source_sel = '0;
    i_sel      = 1'b0;
    x_sel      = 1'b0;
    y_sel      = 1'b0;
    jump_taken = 1'b0;
    halt_op    = 1'b0;
    if (!ir[7]) begin
      // load immediate nibble; a dm destination also post-increments i
      reg_en     = dst_onehot(ir[6:4]);
      source_sel = SRC_SEL_IMM;
      if (ir[6:4] == CODE_DM) begin
        reg_en[EN_I] = 1'b1;
        i_sel        = 1'b1;
      end
    end else if (ir[7:6] == OP_MOV_PREFIX) begin
      if (ir == MOV_IPINS_OPCODE) begin
        source_sel       = SRC_SEL_IPINS;
        reg_en[EN_O_REG] = 1'b1;
      end else if (ir[5:3] == ir[2:0]) begin
`ifdef PROGRAM_SEQUENCER_HALT_EN
        halt_op = (ir == HALT_OPCODE);
`endif
      end else begin
        reg_en     = dst_onehot(ir[5:3]);
        source_sel = {1'b0, ir[2:0]};
        // dm traffic bumps i by m, unless i itself is being loaded
        if ((ir[5:3] == CODE_DM || ir[2:0] == CODE_DM) && ir[5:3] != CODE_I) begin
          reg_en[EN_I] = 1'b1;
          i_sel        = 1'b1;
        end
      end
    end else if (ir[7:5] == OP_ALU_PREFIX) begin
      reg_en[EN_R] = 1'b1;
      x_sel        = ir[4];
      y_sel        = ir[3];
    end else if (ir[7:4] == OP_JMP_PREFIX) begin
      jump_taken = 1'b1;
    end else begin
      jump_taken = !r_eq_0;
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Fetch/execute sequencer: owns pc, ir and the FETCH/EXEC/HALT FSM.
// Define PROGRAM_SEQUENCER_HALT_EN to let opcode 8'hBF park the FSM in HALT.
module program_sequencer
  import program_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       sync_reset,
  input  logic [7:0] pm_data,
  input  logic       r_eq_0,
  output logic [7:0] pc,
  output logic [7:0] ir,
  output logic [8:0] reg_en,
  output logic [3:0] source_sel,
  output logic       i_sel,
  output logic       x_sel,
  output logic       y_sel,
  output logic       halted,
  output state_t     state_dbg
);

  state_t     state, next_state;
  logic [8:0] dec_reg_en;
  logic [3:0] dec_source_sel;
  logic       dec_i_sel, dec_x_sel, dec_y_sel, dec_jump, dec_halt;
  logic       exec_active;

  seq_decoder u_decoder (
    .ir         (ir),
    .r_eq_0     (r_eq_0),
    .reg_en     (dec_reg_en),
    .source_sel (dec_source_sel),
    .i_sel      (dec_i_sel),
    .x_sel      (dec_x_sel),
    .y_sel      (dec_y_sel),
    .jump_taken (dec_jump),
    .halt_op    (dec_halt)
  );

  always_ff @(posedge clk) begin
    if (sync_reset) state <= FETCH;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:   next_state = EXEC;
      EXEC:    next_state = dec_halt ? HALT : FETCH;
      HALT:    next_state = HALT;
      default: next_state = FETCH;
    endcase
  end

  // Reset blanks the controls in the same cycle so no unit register is written
  assign exec_active = (state == EXEC) && !sync_reset;

  always_comb begin
    reg_en     = '0;
    source_sel = '0;
    i_sel      = 1'b0;
    x_sel      = 1'b0;
    y_sel      = 1'b0;
    if (exec_active) begin
      reg_en     = dec_reg_en;
      source_sel = dec_source_sel;
      i_sel      = dec_i_sel;
      x_sel      = dec_x_sel;
      y_sel      = dec_y_sel;
    end
  end

  // pc is already incremented by EXEC, so the jump stays in the next pc's page
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      pc <= 8'h00;
      ir <= 8'h00;
    end else if (state == FETCH) begin
      ir <= pm_data;
      pc <= pc + 8'd1;
    end else if (state == EXEC && dec_jump) begin
      pc <= {pc[7:4], ir[3:0]};
    end
  end

`ifdef PROGRAM_SEQUENCER_HALT_EN
  assign halted = (state == HALT);
`else
  assign halted = 1'b0;
`endif

  assign state_dbg = state;

endmodule
